if_fetch_ctrl: RTL and testbench

- Fetch-stage controller directly downstream of the PC-source 4:1 mux; its `pc_next` input is that mux's output.
- Holds the architectural PC and issues one instruction-memory request at a time with a valid/ready handshake.
- Buffers returned instructions in a 2-entry queue and presents them to ID with valid/ready.
- Discards in-flight fetches on a redirect (branch, jump or exception).

---
 rtl/mips_pkg.sv | 31 +++
 rtl/if_inst_queue.sv | 105 ++++++++++
 rtl/if_inst_queue_chk.sv | 17 +
 rtl/if_fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions.
//   if_state_t   : fetch controller state encoding (IDLE/REQ/WAIT/DROP)
//   DEF_RESET_PC : default PC loaded on reset
//   DEF_PC_INC   : default sequential PC increment
//   IF_Q_DEPTH   : instruction queue depth
//   sat_add32    : saturating increment for 32-bit event counters
package mips_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_DROP = 2'd3
  } if_state_t;

  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam logic [15:0] DEF_PC_INC   = 16'h0004;
  localparam logic [1:0]  IF_Q_DEPTH   = 2'd2;

  // Adds a small increment to a counter, sticking at all-ones.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {31'd0, inc};
    if (sum[32]) begin
      return 32'hFFFF_FFFF;
    end else begin
      return sum[31:0];
    end
  endfunction

endpackage

// File: rtl/if_inst_queue.sv
// 2-entry FIFO of {pc, instr} between instruction memory and ID.
//   clk, rst_n         : clock and async active-low reset
//   push, wr_pc/instr  : write a returned instruction
//   pop                : head consumed by ID (ignored when empty)
//   clr                : flush all entries (wins over push/pop)
//   count              : occupancy 0..2
//   rd_pc, rd_instr    : head entry
module if_inst_queue
  import mips_pkg::*;
#(
  parameter int pc_w    = 16,
  parameter int instr_w = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [pc_w-1:0]    wr_pc,
  input  logic [instr_w-1:0] wr_instr,
  input  logic               pop,
  input  logic               clr,
  output logic [1:0]         count,
  output logic [pc_w-1:0]    rd_pc,
  output logic [instr_w-1:0] rd_instr
);

  logic [pc_w-1:0]    pc0_q, pc0_d, pc1_q, pc1_d;
  logic [instr_w-1:0] ins0_q, ins0_d, ins1_q, ins1_d;
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    pc0_d    = pc0_q;
    pc1_d    = pc1_q;
    ins0_d   = ins0_q;
    ins1_d   = ins1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop && (cnt_q != 2'd0);
    if (clr) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr_q) begin
          pc1_d  = wr_pc;
          ins1_d = wr_instr;
        end else begin
          pc0_d  = wr_pc;
          ins0_d = wr_instr;
        end
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, do_pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc0_q    <= '0;
      pc1_q    <= '0;
      ins0_q   <= '0;
      ins1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
      ins0_q   <= ins0_d;
      ins1_q   <= ins1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign count    = cnt_q;
  assign rd_pc    = rd_ptr_q ? pc1_q  : pc0_q;
  assign rd_instr = rd_ptr_q ? ins1_q : ins0_q;

  if_inst_queue_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .clr   (clr),
    .count (cnt_q)
  );

endmodule

// File: rtl/if_inst_queue_chk.sv
// Simulation checker for the instruction queue.
//   clk, rst_n : clock and async active-low reset
//   push, clr  : queue write and flush strobes
//   count      : current occupancy
module if_inst_queue_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       push,
  input logic       clr,
  input logic [1:0] count
);

  // A push into a full queue would overwrite the oldest unread instruction.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !clr && (count == 2'd2)));

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: holds the PC, issues one instruction-memory
// request at a time, buffers responses in a 2-entry queue for ID and flushes
// on redirect.
//   clk, rst                 : clock, async active-low reset
//   pc_next, redirect        : redirect target from the PC-source mux
//   im_req/im_addr/im_gnt    : memory request handshake
//   im_rvalid/im_rdata       : memory response
//   if_valid/if_instr/if_pc  : instruction to ID, id_ready accepts
//   pc_plus                  : pc + pc_inc, feeds the PC-source mux
// Optional macro IF_FETCH_PERF_EN adds perf_fetched/perf_flushed/perf_stall.
module if_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int                  bit_size   = 16,
  parameter int                  instr_size = 32,
  parameter logic [bit_size-1:0] reset_pc   = bit_size'(DEF_RESET_PC),
  parameter logic [bit_size-1:0] pc_inc     = bit_size'(DEF_PC_INC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [bit_size-1:0]   pc_next,
  input  logic                  redirect,
  output logic                  im_req,
  output logic [bit_size-1:0]   im_addr,
  input  logic                  im_gnt,
  input  logic                  im_rvalid,
  input  logic [instr_size-1:0] im_rdata,
  output logic                  if_valid,
  output logic [instr_size-1:0] if_instr,
  output logic [bit_size-1:0]   if_pc,
  input  logic                  id_ready,
  output logic [bit_size-1:0]   pc_plus
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushed,
  output logic [31:0]           perf_stall
`endif
);

  if_state_t           state_q, state_d;
  logic [bit_size-1:0] pc_q, pc_d;
  logic [bit_size-1:0] pend_pc_q, pend_pc_d;
  logic                q_push, q_pop, q_clr;
  logic [1:0]          q_count;

  // Fetch FSM: request issue, response capture and redirect handling.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    im_req    = 1'b0;
    q_push    = 1'b0;
    q_clr     = 1'b0;
    case (state_q)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ: begin
        // Only request when the response is guaranteed a queue slot.
        im_req = (q_count < IF_Q_DEPTH);
        if (im_req && im_gnt) begin
          pend_pc_d = pc_q;
          pc_d      = pc_q + pc_inc;
          state_d   = IF_WAIT;
        end else begin
          state_d = IF_REQ;
        end
      end
      IF_WAIT: begin
        if (im_rvalid) begin
          q_push  = 1'b1;
          state_d = IF_REQ;
        end else begin
          state_d = IF_WAIT;
        end
      end
      IF_DROP: begin
        if (im_rvalid) begin
          state_d = IF_REQ;
        end else begin
          state_d = IF_DROP;
        end
      end
      default: state_d = IF_IDLE;
    endcase
    if (redirect) begin
      pc_d   = pc_next;
      q_clr  = 1'b1;
      q_push = 1'b0;
      case (state_q)
        // A granted request belongs to memory now; its response must be eaten.
        IF_REQ:           state_d = (im_req && im_gnt) ? IF_DROP : IF_REQ;
        IF_WAIT, IF_DROP: state_d = im_rvalid ? IF_REQ : IF_DROP;
        default:          state_d = IF_REQ;
      endcase
    end else begin
      q_clr = 1'b0;
    end
  end

  // FSM and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IF_IDLE;
      pc_q      <= reset_pc;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign im_addr  = pc_q;
  assign pc_plus  = pc_q + pc_inc;
  assign if_valid = (q_count != 2'd0);
  assign q_pop    = if_valid && id_ready;

  if_inst_queue #(
    .pc_w    (bit_size),
    .instr_w (instr_size)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst),
    .push     (q_push),
    .wr_pc    (pend_pc_q),
    .wr_instr (im_rdata),
    .pop      (q_pop),
    .clr      (q_clr),
    .count    (q_count),
    .rd_pc    (if_pc),
    .rd_instr (if_instr)
  );

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d, flushed_q, flushed_d, stall_q, stall_d;
  logic [1:0]  flush_inc;

  // Event counters; a transfer in a redirect cycle is flushed, not fetched.
  always_comb begin
    if (redirect) begin
      flush_inc = q_count +
        ((im_rvalid && ((state_q == IF_WAIT) || (state_q == IF_DROP))) ? 2'd1 : 2'd0);
    end else if ((state_q == IF_DROP) && im_rvalid) begin
      flush_inc = 2'd1;
    end else begin
      flush_inc = 2'd0;
    end
    fetched_d = sat_add32(fetched_q, {1'b0, q_pop && !redirect});
    flushed_d = sat_add32(flushed_q, flush_inc);
    stall_d   = sat_add32(stall_q, {1'b0, !if_valid && id_ready});
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= 32'd0;
      flushed_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_next = 16'd0;
  logic        redirect = 1'b0;
  logic        im_req;
  logic [15:0] im_addr;
  logic        im_gnt = 1'b0;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = 32'd0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready = 1'b0;
  logic [15:0] pc_plus;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .pc_next   (pc_next),
    .redirect  (redirect),
    .im_req    (im_req),
    .im_addr   (im_addr),
    .im_gnt    (im_gnt),
    .im_rvalid (im_rvalid),
    .im_rdata  (im_rdata),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .id_ready  (id_ready),
    .pc_plus   (pc_plus)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed),
    .perf_stall   (perf_stall)
`endif
  );

  int nchecks = 0;
  int nerr    = 0;

  // Stimulus knobs.
  int          k_dmin = 1, k_dmax = 1;
  bit          k_gnt_rand = 1'b0, k_ready_rand = 1'b0;
  logic        k_ready = 1'b1;
  bit          k_redir = 1'b0;
  logic [15:0] k_pc_next = 16'd0;

  // Memory model: one outstanding request, response after a delay.
  bit          mem_out = 1'b0;
  int          mem_wait = 0;
  logic [15:0] mem_addr = 16'd0;

  // Reference model: next address memory should see, next PC ID should see.
  logic [15:0] exp_fetch = 16'd0;
  logic [15:0] exp_pc = 16'd0;
  logic [15:0] prev_grant = 16'd0;
  bit          saw_wrap = 1'b0;
  int          n_xfer = 0;
  int          n;
  bit          found;

  function automatic logic [31:0] word_at(input logic [15:0] a);
    return {a ^ 16'h5A3C, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check, update models.
  task automatic step();
    logic [15:0] nxt;
    redirect = k_redir;
    pc_next  = k_redir ? k_pc_next : 16'($urandom);
    id_ready = k_ready_rand ? 1'($urandom_range(0, 1)) : k_ready;
    im_gnt   = k_gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mem_out && (mem_wait == 0)) begin
      im_rvalid = 1'b1;
      im_rdata  = word_at(mem_addr);
    end else begin
      im_rvalid = 1'b0;
      im_rdata  = $urandom;
    end
    #1;
    if (im_req) begin
      nxt = exp_fetch + 16'd4;
      chk("pc_plus", 32'(pc_plus), 32'(nxt));
    end
    if (im_req && im_gnt) begin
      chk("im_addr", 32'(im_addr), 32'(exp_fetch));
      chk("single_outstanding", 32'(mem_out), 32'd0);
      if ((im_addr == 16'h0000) && (prev_grant == 16'hFFFC)) saw_wrap = 1'b1;
      prev_grant = im_addr;
      exp_fetch  = exp_fetch + 16'd4;
    end
    if (if_valid && id_ready && !redirect) begin
      chk("if_pc", 32'(if_pc), 32'(exp_pc));
      chk("if_instr", if_instr, word_at(exp_pc));
      exp_pc = exp_pc + 16'd4;
      n_xfer++;
    end
    if (redirect) begin
      exp_fetch = k_pc_next;
      exp_pc    = k_pc_next;
    end
    if (im_rvalid) begin
      mem_out = 1'b0;
    end else if (mem_out) begin
      mem_wait--;
    end
    if (im_req && im_gnt) begin
      mem_out  = 1'b1;
      mem_addr = im_addr;
      mem_wait = int'($urandom_range(k_dmin, k_dmax)) - 1;
    end
    k_redir = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_im_req"},   32'(im_req),   32'd0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_if_instr"}, if_instr,      32'd0);
    chk({tag, "_if_pc"},    32'(if_pc),    32'd0);
    chk({tag, "_pc_plus"},  32'(pc_plus),  32'd4);
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");

    // Ideal memory: first valid 3 cycles after release, 1 instr per 2 cycles.
    rst = 1'b1;
    n = 0;
    while (!if_valid && (n < 10)) begin
      step();
      n++;
    end
    chk("first_valid_latency", 32'(n), 32'd3);
    chk("first_if_pc", 32'(if_pc), 32'd0);
    repeat (8) step();
    chk("ideal_xfer_pc", 32'(exp_pc), 32'h10);
    chk("ideal_fetch_pc", 32'(exp_fetch), 32'h14);

    // Asynchronous reset in the middle of WAIT.
    k_dmin = 3; k_dmax = 3;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_out && (mem_wait > 0)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("found_wait_for_reset", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("async_reset");
    im_rvalid = 1'b0;
    redirect  = 1'b0;
    mem_out   = 1'b0;
    exp_fetch = 16'd0;
    exp_pc    = 16'd0;
    @(negedge clk);
    rst = 1'b1;

    // ID stall: queue fills with 0 and 4, requests stop, nothing is lost.
    k_dmin = 1; k_dmax = 1;
    k_ready = 1'b0;
    repeat (10) step();
    chk("stall_im_req", 32'(im_req), 32'd0);
    chk("stall_if_valid", 32'(if_valid), 32'd1);
    chk("stall_head_pc", 32'(if_pc), 32'd0);
    chk("stall_head_instr", if_instr, word_at(16'd0));
    chk("stall_fetches", 32'(exp_fetch), 32'd8);
    k_ready = 1'b1;
    repeat (12) step();
    chk("stall_release_progress", 32'(exp_pc >= 16'h000C), 32'd1);

    // Redirect while waiting for a response.
    k_dmin = 3; k_dmax = 3;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_out && (mem_wait > 0)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("found_wait_for_redirect", 32'(found), 32'd1);
    k_redir = 1'b1; k_pc_next = 16'h0100;
    step();
    k_dmin = 1; k_dmax = 1;
    for (int i = 0; i < 20; i++) begin
      if (if_valid) break;
      step();
    end
    chk("redir_wait_valid", 32'(if_valid), 32'd1);
    chk("redir_wait_pc", 32'(if_pc), 32'h0100);

    // Redirect together with a grant: response must be dropped.
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (im_req) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("found_req_for_redirect", 32'(found), 32'd1);
    k_dmin = 2; k_dmax = 2;
    k_redir = 1'b1; k_pc_next = 16'h0200;
    step();
    chk("drop_no_req", 32'(im_req), 32'd0);
    k_dmin = 1; k_dmax = 1;
    for (int i = 0; i < 20; i++) begin
      if (if_valid) break;
      step();
    end
    chk("redir_gnt_valid", 32'(if_valid), 32'd1);
    chk("redir_gnt_pc", 32'(if_pc), 32'h0200);

    // PC wrap at the top of the 16-bit space.
    k_redir = 1'b1; k_pc_next = 16'hFFF8;
    step();
    repeat (10) step();
    chk("pc_wrap_seen", 32'(saw_wrap), 32'd1);

    // Random memory timing, ID back-pressure and redirects.
    k_gnt_rand = 1'b1; k_ready_rand = 1'b1;
    k_dmin = 1; k_dmax = 4;
    n_xfer = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        k_redir   = 1'b1;
        k_pc_next = 16'($urandom) & 16'hFFFC;
      end
      step();
    end
    chk("random_progress", 32'(n_xfer > 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
